mole_controller: RTL and testbench

Game-round sequencer for the whack-a-mole datapath. It sits directly downstream of the 3-bit LFSR box selector. It requests a new pseudo-random state, maps it to one of four boxes, and raises the mole for a bounded window. It then scores player hits, counts misses, and ends the game after a fixed number of misses.

---
 rtl/mole_controller_if.sv | 45 ++++
 rtl/mole_controller.sv | 147 ++++++++++++++
 tb/tb_mole_controller.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mole_controller_if
// Description : Game-side signal bundle between the whack-a-mole round
//               sequencer (slave) and the surrounding datapath (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface mole_controller_if;
    logic       start;
    logic [2:0] lfsr_in;
    logic       lfsr_enable;
    logic [3:0] hit;
    logic       mole_up;
    logic [1:0] mole_box;
    logic [7:0] score;
    logic [3:0] misses;
    logic       game_over;

    // Datapath / stimulus side
    modport master (
        output start,
        output lfsr_in,
        output hit,
        input  lfsr_enable,
        input  mole_up,
        input  mole_box,
        input  score,
        input  misses,
        input  game_over
    );

    // Round sequencer side
    modport slave (
        input  start,
        input  lfsr_in,
        input  hit,
        output lfsr_enable,
        output mole_up,
        output mole_box,
        output score,
        output misses,
        output game_over
    );
endinterface
`default_nettype wire

// File: rtl/mole_controller.sv
`default_nettype none
// ============================================================================
// Module      : mole_controller
// Description : Whack-a-mole round sequencer. Waits an empty-field gap,
//               advances the upstream LFSR, maps its state to one of four
//               boxes, shows the mole for a bounded window, scores hits,
//               counts misses and ends the game after MAX_MISSES misses.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_controller #(
    parameter int GAP_CYCLES = 25_000_000,
    parameter int UP_CYCLES  = 50_000_000,
    parameter int MAX_MISSES = 3
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mole_controller_if.slave  bus
);

    // One shared down-counter times both the gap and the up window
    localparam int CNT_MAX = (GAP_CYCLES > UP_CYCLES) ? GAP_CYCLES : UP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] C_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_UP_LOAD   = CNT_W'(UP_CYCLES - 1);
    localparam logic [3:0]       C_MAX_MISS  = 4'(MAX_MISSES);
    localparam logic [7:0]       C_SCORE_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GAP       = 3'd1,
        ST_SPAWN     = 3'd2,
        ST_LATCH     = 3'd3,
        ST_UP        = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       box_q,      box_d;
    logic [7:0]       score_q,    score_d;
    logic [3:0]       misses_q,   misses_d;

    logic [3:0]       misses_inc;
    logic             hit_match;
    logic             cnt_zero;

    // LFSR state to box index; the non-uniform folding of eight codes onto
    // four boxes is intentional and matches the upstream selector.
    function automatic logic [1:0] map_box(input logic [2:0] code);
        logic [1:0] box;
        case (code)
            3'b001, 3'b010, 3'b100: box = 2'd0;
            3'b011, 3'b101:         box = 2'd1;
            3'b110:                 box = 2'd2;
            default:                box = 2'd3;   // 3'b111, 3'b000
        endcase
        return box;
    endfunction

    assign misses_inc = misses_q + 4'd1;
    assign hit_match  = bus.hit[box_q];
    assign cnt_zero   = (cnt_q == '0);

    // Next-state, counter and scoreboard update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        box_d    = box_q;
        score_d  = score_q;
        misses_d = misses_q;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (bus.start) begin
                    state_d  = ST_GAP;
                    cnt_d    = C_GAP_LOAD;
                    score_d  = 8'd0;
                    misses_d = 4'd0;
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d = ST_SPAWN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SPAWN: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                // LFSR advanced at the end of SPAWN, so lfsr_in is fresh here
                box_d   = map_box(bus.lfsr_in);
                cnt_d   = C_UP_LOAD;
                state_d = ST_UP;
            end
            ST_UP: begin
                // A hit takes priority over expiry in the final up cycle
                if (hit_match) begin
                    score_d = (score_q == C_SCORE_MAX) ? score_q : score_q + 8'd1;
                    cnt_d   = C_GAP_LOAD;
                    state_d = ST_GAP;
                end else if (cnt_zero) begin
                    misses_d = misses_inc;
                    if (misses_inc == C_MAX_MISS) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        cnt_d   = C_GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            box_q    <= 2'd0;
            score_q  <= 8'd0;
            misses_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            box_q    <= box_d;
            score_q  <= score_d;
            misses_q <= misses_d;
        end
    end

    assign bus.lfsr_enable = (state_q == ST_SPAWN);
    assign bus.mole_up     = (state_q == ST_UP);
    assign bus.game_over   = (state_q == ST_GAME_OVER);
    assign bus.mole_box    = box_q;
    assign bus.score       = score_q;
    assign bus.misses      = misses_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mole_controller
// Description : Directed self-checking bench for mole_controller with
//               GAP_CYCLES=4, UP_CYCLES=6, MAX_MISSES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_controller;

    localparam int GAP = 4;
    localparam int UPC = 6;
    localparam int MAXM = 3;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mole_controller_if bus ();

    mole_controller #(
        .GAP_CYCLES (GAP),
        .UP_CYCLES  (UPC),
        .MAX_MISSES (MAXM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic [1:0] exp_box;
        logic [7:0] exp_score;
    } box_vec_t;

    box_vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_up();
        int n;
        n = 0;
        while (bus.mole_up !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (bus.mole_up !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_up: got timeout expected mole_up within 30 cycles");
        end
    endtask

    task automatic wait_down();
        int n;
        n = 0;
        while (bus.mole_up === 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (bus.mole_up === 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_down: got timeout expected mole_up to fall within 30 cycles");
        end
    endtask

    task automatic hit_mole();
        wait_up();
        bus.hit = 4'b1111;
        step();
        bus.hit = 4'b0000;
    endtask

    initial begin
        int en_cnt;
        int en_at;
        int up_cnt;
        int first_up;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start   = 1'b0;
        bus.lfsr_in = 3'b001;
        bus.hit     = 4'b0000;

        vecs[0] = '{3'b001, 2'd0, 8'd1};
        vecs[1] = '{3'b010, 2'd0, 8'd2};
        vecs[2] = '{3'b100, 2'd0, 8'd3};
        vecs[3] = '{3'b011, 2'd1, 8'd4};
        vecs[4] = '{3'b101, 2'd1, 8'd5};
        vecs[5] = '{3'b110, 2'd2, 8'd6};
        vecs[6] = '{3'b111, 2'd3, 8'd7};
        vecs[7] = '{3'b000, 2'd3, 8'd8};

        // ---------------- reset state
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_lfsr_enable", 32'(bus.lfsr_enable), 0);
        chk("rst_mole_up",     32'(bus.mole_up),     0);
        chk("rst_mole_box",    32'(bus.mole_box),    0);
        chk("rst_score",       32'(bus.score),       0);
        chk("rst_misses",      32'(bus.misses),      0);
        chk("rst_game_over",   32'(bus.game_over),   0);

        // ---------------- first-round timing, mole not hit
        bus.lfsr_in = 3'b110;
        pulse_start();
        en_cnt = 0; en_at = 0; up_cnt = 0; first_up = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.lfsr_enable === 1'b1) begin
                en_cnt++;
                en_at = k;
            end
            if (bus.mole_up === 1'b1) begin
                up_cnt++;
                if (first_up == 0) first_up = k;
            end
        end
        chk("enable_pulses",  32'(en_cnt),   1);
        chk("enable_cycle",   32'(en_at),    GAP);
        chk("mole_up_first",  32'(first_up), GAP + 2);
        chk("mole_up_len",    32'(up_cnt),   UPC);
        chk("first_miss",     32'(bus.misses), 1);

        // start in GAP must not clear misses
        pulse_start();
        step();
        chk("start_in_gap_ignored", 32'(bus.misses), 1);

        // ---------------- box map table
        for (int i = 0; i < 8; i++) begin
            bus.lfsr_in = vecs[i].code;
            wait_up();
            chk($sformatf("box_map_%0d", i), 32'(bus.mole_box), 32'(vecs[i].exp_box));
            bus.hit = 4'b1111;
            step();
            bus.hit = 4'b0000;
            chk($sformatf("box_hit_down_%0d", i), 32'(bus.mole_up), 0);
            chk($sformatf("box_score_%0d", i),    32'(bus.score),   32'(vecs[i].exp_score));
        end

        // ---------------- wrong box then right box, with start in UP
        bus.lfsr_in = 3'b110;
        wait_up();
        chk("box2_select", 32'(bus.mole_box), 2);
        bus.hit   = 4'b0001;
        bus.start = 1'b1;
        step();
        bus.hit   = 4'b0000;
        bus.start = 1'b0;
        chk("wrong_hit_still_up", 32'(bus.mole_up), 1);
        chk("wrong_hit_score",    32'(bus.score),   8);
        bus.hit = 4'b0100;
        step();
        bus.hit = 4'b0000;
        chk("right_hit_down",   32'(bus.mole_up), 0);
        chk("right_hit_score",  32'(bus.score),   9);
        chk("right_hit_misses", 32'(bus.misses),  1);

        // ---------------- hit in the final up cycle
        wait_up();
        for (int k = 0; k < UPC - 1; k++) step();
        chk("last_cycle_still_up", 32'(bus.mole_up), 1);
        bus.hit = 4'b0100;
        step();
        bus.hit = 4'b0000;
        chk("last_cycle_down",   32'(bus.mole_up), 0);
        chk("last_cycle_score",  32'(bus.score),   10);
        chk("last_cycle_misses", 32'(bus.misses),  1);

        // ---------------- score saturation
        for (int i = 0; i < 245; i++) hit_mole();
        chk("score_reach_255", 32'(bus.score), 255);
        hit_mole();
        chk("score_sat_255",   32'(bus.score), 255);
        chk("score_sat_misses", 32'(bus.misses), 1);

        // ---------------- run out remaining misses
        wait_up();
        wait_down();
        chk("miss2_count",    32'(bus.misses),    2);
        chk("miss2_not_over", 32'(bus.game_over), 0);
        wait_up();
        wait_down();
        chk("miss3_count", 32'(bus.misses),    3);
        chk("miss3_over",  32'(bus.game_over), 1);
        for (int k = 0; k < 10; k++) step();
        chk("over_hold",        32'(bus.game_over),   1);
        chk("over_misses_hold", 32'(bus.misses),      3);
        chk("over_no_enable",   32'(bus.lfsr_enable), 0);

        // ---------------- restart from GAME_OVER, fresh miss count
        pulse_start();
        chk("restart_score",  32'(bus.score),     0);
        chk("restart_misses", 32'(bus.misses),    0);
        chk("restart_over",   32'(bus.game_over), 0);
        for (int i = 1; i <= MAXM; i++) begin
            wait_up();
            wait_down();
            chk($sformatf("miss_seq_%0d", i),  32'(bus.misses),    32'(i));
            chk($sformatf("over_seq_%0d", i),  32'(bus.game_over), (i == MAXM) ? 1 : 0);
        end

        // ---------------- reset while UP with score 5
        pulse_start();
        for (int i = 0; i < 5; i++) hit_mole();
        bus.lfsr_in = 3'b111;
        wait_up();
        chk("pre_reset_score", 32'(bus.score),    5);
        chk("pre_reset_box",   32'(bus.mole_box), 3);
        reset = 1'b1;
        bus.hit = 4'b1000;
        step();
        bus.hit = 4'b0000;
        reset = 1'b0;
        chk("mid_rst_mole_up",   32'(bus.mole_up),     0);
        chk("mid_rst_box",       32'(bus.mole_box),    0);
        chk("mid_rst_score",     32'(bus.score),       0);
        chk("mid_rst_misses",    32'(bus.misses),      0);
        chk("mid_rst_over",      32'(bus.game_over),   0);
        chk("mid_rst_enable",    32'(bus.lfsr_enable), 0);
        for (int k = 0; k < 10; k++) step();
        chk("idle_stays_quiet", 32'({bus.mole_up, bus.lfsr_enable, bus.game_over}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected run to finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
